// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared types and geometry helpers for the direct-mapped refill I-cache.
//   state_e     : controller state encoding (IDLE, LOOKUP, MISS_REQ, REFILL, RESP)
//   tag_w()     : tag width for a given ADDR_W / INDEX_W / OFFSET_W
//   words()     : 32-bit words per line for a given OFFSET_W
//   line_index(): line index field of a byte address
//   line_tag()  : tag field of a byte address
//   word_sel()  : word-within-line field of a byte address
// The field helpers return 64-bit values; callers cast to the field width.
// -----------------------------------------------------------------------------
package icache_pkg;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_INDEX_W  = 7;
  localparam int DEF_OFFSET_W = 5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_MISS_REQ = 3'd2,
    S_REFILL   = 3'd3,
    S_RESP     = 3'd4
  } state_e;

  function automatic int tag_w(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction

  function automatic int words(input int offset_w);
    return 1 << (offset_w - 2);
  endfunction

  function automatic logic [63:0] line_index(input logic [63:0] addr, input int index_w,
                                             input int offset_w);
    return (addr >> offset_w) & ((64'd1 << index_w) - 64'd1);
  endfunction

  function automatic logic [63:0] line_tag(input logic [63:0] addr, input int index_w,
                                           input int offset_w);
    return addr >> (index_w + offset_w);
  endfunction

  function automatic logic [63:0] word_sel(input logic [63:0] addr, input int offset_w);
    return (addr >> 2) & ((64'd1 << (offset_w - 2)) - 64'd1);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// -----------------------------------------------------------------------------
// icache_line_store
// Tag, valid and data arrays of the direct-mapped cache.
//   clk, rst                  : clock, asynchronous active-high reset (valid bits only)
//   rd_idx, rd_word           : read port address; rd_data/rd_tag/rd_valid are
//                               combinational
//   wr_en, wr_idx, wr_word,
//   wr_data                   : single refill word write
//   set_en, set_idx, set_tag,
//   set_valid                 : write the line tag; set_valid also marks it valid
//   flush                     : clear every valid bit at the clock edge; wins
//                               over a valid set in the same cycle
// Tag and data arrays are not reset; only the valid bits are.
// -----------------------------------------------------------------------------
module icache_line_store #(
  parameter int INDEX_W = 7,
  parameter int WSEL_W  = 3,
  parameter int TAG_W   = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_idx,
  input  logic [WSEL_W-1:0]  rd_word,
  output logic [31:0]        rd_data,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [WSEL_W-1:0]  wr_word,
  input  logic [31:0]        wr_data,
  input  logic               set_en,
  input  logic [INDEX_W-1:0] set_idx,
  input  logic [TAG_W-1:0]   set_tag,
  input  logic               set_valid,
  input  logic               flush
);

  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << WSEL_W;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_mem  [0:LINES-1];
  logic [31:0]      data_mem [0:LINES*WORDS-1];

  assign rd_data  = data_mem[{rd_idx, rd_word}];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_valid = valid_q[rd_idx];

  always_comb begin
    valid_d = valid_q;
    if (set_en && set_valid) valid_d[set_idx] = 1'b1;
    // Flush is applied last so it overrides a same-cycle valid set.
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en)  data_mem[{wr_idx, wr_word}] <= wr_data;
    if (set_en) tag_mem[set_idx] <= set_tag;
  end

endmodule

// File: rtl/icache_dm_refill.sv
// -----------------------------------------------------------------------------
// icache_dm_refill
// Direct-mapped instruction cache with one-cycle hits and burst line refill.
//   clk, reset        : clock, asynchronous active-high reset
//   req_valid/ready   : fetch request handshake, req_addr byte address
//   inst_valid, inst  : one-cycle response pulse; inst holds between pulses
//   flush             : invalidate all lines
//   mem_req_valid/ready, mem_req_addr : line refill request (line aligned)
//   mem_resp_valid, mem_resp_data     : refill beats, ascending word order
// Optional build macro ICACHE_PERF_CNT_EN adds saturating hit_cnt / miss_cnt
// outputs counting LOOKUP outcomes.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The cache holds mem_req_valid and mem_req_addr stable until
// mem_req_ready; mem_resp_valid has no back-pressure and is only consumed
// in REFILL. req_ready may depend combinationally on the current lookup.
// -----------------------------------------------------------------------------
module icache_dm_refill
  import icache_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int INDEX_W  = DEF_INDEX_W,
  parameter int OFFSET_W = DEF_OFFSET_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              inst_valid,
  output logic [31:0]       inst,
  input  logic              flush,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int TAG_W  = tag_w(ADDR_W, INDEX_W, OFFSET_W);
  localparam int WORDS  = words(OFFSET_W);
  localparam int WSEL_W = OFFSET_W - 2;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WSEL_W-1:0]   cnt_q, cnt_d;
  logic                flushed_q, flushed_d;
  logic [31:0]         inst_hold_q, inst_hold_d;

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic [WSEL_W-1:0]   wsel;
  logic [31:0]         rd_data;
  logic [TAG_W-1:0]    rd_tag;
  logic                rd_valid;
  logic                lookup_hit;
  logic                beat_wr;
  logic                last_beat;

  // Captured request address drives both the lookup and the refill.
  assign idx  = INDEX_W'(line_index(64'(addr_q), INDEX_W, OFFSET_W));
  assign tag  = TAG_W'(line_tag(64'(addr_q), INDEX_W, OFFSET_W));
  assign wsel = WSEL_W'(word_sel(64'(addr_q), OFFSET_W));

  // A flush in the lookup cycle takes effect first, so the lookup misses.
  assign lookup_hit = (state_q == S_LOOKUP) && rd_valid && !flush && (rd_tag == tag);
  assign beat_wr    = (state_q == S_REFILL) && mem_resp_valid;
  assign last_beat  = beat_wr && (cnt_q == WSEL_W'(WORDS - 1));

  icache_line_store #(
    .INDEX_W (INDEX_W),
    .WSEL_W  (WSEL_W),
    .TAG_W   (TAG_W)
  ) u_store (
    .clk       (clk),
    .rst       (reset),
    .rd_idx    (idx),
    .rd_word   (wsel),
    .rd_data   (rd_data),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .wr_en     (beat_wr),
    .wr_idx    (idx),
    .wr_word   (cnt_q),
    .wr_data   (mem_resp_data),
    .set_en    (last_beat),
    .set_idx   (idx),
    .set_tag   (tag),
    // A flush seen at any point of this miss keeps the new line invalid.
    .set_valid (!flushed_q),
    .flush     (flush)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      flushed_q   <= 1'b0;
      inst_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      flushed_q   <= flushed_d;
      inst_hold_q <= inst_hold_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    flushed_d   = flushed_q;
    inst_hold_d = inst_valid ? rd_data : inst_hold_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (lookup_hit) begin
          // Back-to-back hits stay in LOOKUP with the next address.
          if (req_valid) addr_d = req_addr;
          else           state_d = S_IDLE;
        end else begin
          flushed_d = 1'b0;
          state_d   = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        if (flush) flushed_d = 1'b1;
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        if (flush) flushed_d = 1'b1;
        if (beat_wr) begin
          cnt_d = cnt_q + WSEL_W'(1);
          if (last_beat) state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready     = (state_q == S_IDLE) || lookup_hit;
    inst_valid    = lookup_hit || (state_q == S_RESP);
    inst          = inst_valid ? rd_data : inst_hold_q;
    mem_req_valid = (state_q == S_MISS_REQ);
    mem_req_addr  = '0;
    if (state_q == S_MISS_REQ) mem_req_addr = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (lookup_hit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + 32'd1;
    if ((state_q == S_LOOKUP) && !lookup_hit && (miss_cnt_q != '1))
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: doc/icache_dm_refill.md
Name: icache_dm_refill

Overview:
Parametrised direct-mapped instruction cache between the fetch stage and the instruction memory bus. It returns a hit in one cycle. On a miss it performs a burst line refill from memory through a valid/ready handshake, then delivers the instruction. It adds miss handling, a flush, and a configurable geometry to the fixed hit-only cache.

Parameters:
ADDR_W, 32, byte address width
INDEX_W, 7, line index bits (2^INDEX_W lines)
OFFSET_W, 5, byte offset bits (line = 2^OFFSET_W bytes, minimum 3)
Derived (package): TAG_W = ADDR_W-INDEX_W-OFFSET_W; WORDS = 2^(OFFSET_W-2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
req_valid  in  1  fetch request
req_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored
req_ready  out  1  cache can accept a request this cycle
inst_valid  out  1  inst valid, one-cycle pulse per request
inst  out  32  fetched instruction, little-endian word
flush  in  1  invalidate all lines
mem_req_valid  out  1  line refill request
mem_req_addr  out  ADDR_W  line-aligned address (offset bits zero)
mem_req_ready  in  1  memory accepts request
mem_resp_valid  in  1  refill beat valid
mem_resp_data  in  32  refill word, beats in ascending word order

Behaviour:
- Reset (async): all valid bits 0; state IDLE; req_ready=1; inst_valid=0; inst=0; mem_req_valid=0; mem_req_addr=0. Tag and data arrays are not reset.
- States: IDLE, LOOKUP, MISS_REQ, REFILL, RESP.
- IDLE: req_ready=1. A request is accepted when req_valid&req_ready. Capture the address and go to LOOKUP.
- LOOKUP (cycle after accept): hit = valid[idx] & tag[idx]==addr tag.
  - On hit: inst_valid=1 with word addr[OFFSET_W-1:2] this cycle. req_ready=1, so a back-to-back request can be accepted: hit throughput is 1 per cycle, latency 1.
  - On miss: req_ready=0, go to MISS_REQ.
- MISS_REQ: hold mem_req_valid=1 and a stable mem_req_addr until mem_req_ready. Then go to REFILL, with the beat counter at 0.
- REFILL:
  - Each mem_resp_valid writes data[idx][cnt] and increments cnt.
  - The last beat (cnt==WORDS-1) writes the tag, sets valid[idx], and goes to RESP.
  - Gaps between beats are allowed.
- RESP: inst_valid=1 with the requested word, read from the refilled line. Return to IDLE. Miss latency = handshake + WORDS beats + 1.
- inst holds its last value while inst_valid=0.
- Flush:
  - When flush=1, all valid bits are cleared at the clock edge.
  - Flush in IDLE or LOOKUP: a lookup in the same cycle is evaluated after the clear, so it is a miss.
  - Flush during MISS_REQ or REFILL: the refill completes and the requester still receives the instruction in RESP, but valid[idx] is not set.
  - Flush has priority over the valid set on the final beat in the same cycle.
- mem_resp_valid outside REFILL is ignored.
- Reset mid-refill aborts immediately. Memory must not issue further beats after reset.
- Indices wrap naturally; no special handling for the top line.

Optional Feature:
ICACHE_PERF_CNT_EN:
- When defined, adds output ports hit_cnt[31:0] and miss_cnt[31:0].
- Each increments once per LOOKUP hit or miss respectively, saturating at 32'hFFFFFFFF.
- Both are cleared by reset; flush does not clear them.
- When undefined, the ports and counters are absent.

Decomposition:
- Package icache_pkg: state enum, and TAG_W/WORDS/idx-slice helper functions parameterised by ADDR_W, INDEX_W, OFFSET_W.
- Sub-module icache_line_store: tag, valid and data arrays, with one read port (combinational word select), a word write port, a tag/valid set port and a flush-all port.
- Top level holds the FSM, beat counter and handshake.

Test Plan:
- Cold miss: after reset, read addr 0x0000_1004, memory returns 0x11..0x88 words (8 beats) -> one mem_req at 0x0000_1000; inst_valid with inst=word1 after the last beat +1 cycle.
- Hit stream: re-request 0x1000, 0x1004, 0x1008 back-to-back -> no mem_req; inst_valid on 3 consecutive cycles with words 0,1,2.
- Conflict: request 0x0000_2004 (same index, tag differs) -> miss and refill; then 0x1004 misses again.
- Handshake stalls: hold mem_req_ready=0 for 5 cycles, insert 2-cycle gaps between beats -> mem_req_addr stable, correct inst, req_ready=0 throughout.
- Flush: flush during the third refill beat -> inst is still delivered; the immediate re-request of the same address misses.
- Reset mid-REFILL, then request -> fresh MISS_REQ, all earlier lines miss; with ICACHE_PERF_CNT_EN, counters read 0 after reset.
